waterfall_led_driver: RTL and testbench

WATERFALL_LED_DRIVER -- requirements
Module: waterfall_led_driver

---
 rtl/waterfall_led_driver.sv | 79 +++++++
 tb/tb_waterfall_led_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/waterfall_led_driver.sv
// Waterfall LED driver: synchronises a slow position input, keeps a decaying
// brightness trail per LED and renders it with a 4-phase PWM.
module waterfall_led_driver #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] pos,
  input  logic       blank,
  output logic [7:0] led,
  output logic       dir,
  output logic       step
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [2:0]    s1, s2, s3;
  logic [2:0]    cur_pos;
  logic [1:0]    lvl     [8];
  logic [1:0]    lvl_nxt [8];
  logic [CW-1:0] cnt;
  logic [1:0]    ph;
  logic          accept;
  logic [7:0]    led_nxt;

  // A position counts only once two consecutive synchronised samples agree.
  assign accept = (s2 == s3) && (s2 != cur_pos);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl_nxt[i] = lvl[i];
      if (accept) lvl_nxt[i] = (lvl[i] == 2'd0) ? 2'd0 : lvl[i] - 2'd1;
    end
    if (accept) lvl_nxt[s2] = 2'd3;
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < 8; i++)
      led_nxt[i] = !blank && ((lvl[i] == 2'd3) || (lvl[i] > ph));
  end

  // NOTE: sequential state uses non-blocking assignments only; the small level
  // array is reset explicitly because the trail must restart from LED 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      cur_pos <= '0;
      for (int i = 0; i < 8; i++) lvl[i] <= (i == 0) ? 2'd3 : 2'd0;
      cnt     <= '0;
      ph      <= '0;
      dir     <= 1'b1;
      step    <= 1'b0;
      led     <= '0;
    end else begin
      s1 <= pos;
      s2 <= s1;
      s3 <= s2;
      for (int i = 0; i < 8; i++) lvl[i] <= lvl_nxt[i];
      step <= accept;
      if (accept) begin
        cur_pos <= s2;
        dir     <= (s2 > cur_pos);
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        ph  <= ph + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_waterfall_led_driver.sv
// Directed bench for waterfall_led_driver with PRESCALE = 4 (16-cycle PWM period).
module tb_waterfall_led_driver;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [2:0] pos = '0;
  logic       blank = 1'b0;
  logic [7:0] led;
  logic       dir;
  logic       step;

  int errors = 0;
  int checks = 0;
  int hi [8];

  typedef struct {
    logic [2:0] pos;
    logic [7:0] exp_led;
    logic       exp_step;
    logic       exp_dir;
  } vec_t;

  vec_t vecs [21];

  waterfall_led_driver #(.PRESCALE(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .pos   (pos),
    .blank (blank),
    .led   (led),
    .dir   (dir),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // Ticks until step is seen; returns the number of edges taken (20 = timeout).
  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 20);
  endtask

  // Counts high cycles per LED over one full PWM period.
  task automatic duty16();
    for (int i = 0; i < 8; i++) hi[i] = 0;
    repeat (16) begin
      tick();
      for (int i = 0; i < 8; i++) hi[i] += int'(led[i]);
    end
  endtask

  initial begin
    int n, bad, steps;

    // Reset state and long hold at position 0.
    do_reset();
    check("reset_led", 32'(led), 32'h00);
    check("reset_step", 32'(step), 32'h0);
    check("reset_dir", 32'(dir), 32'h1);
    bad = 0;
    steps = 0;
    tick();
    check("first_edge_led", 32'(led), 32'h01);
    repeat (1000) begin
      tick();
      if (led !== 8'h01 || dir !== 1'b1) bad++;
      if (step === 1'b1) steps++;
    end
    check("hold0_bad_cycles", 32'(bad), 32'd0);
    check("hold0_steps", 32'(steps), 32'd0);

    // Cycle-accurate ascending run 0 -> 1 -> 2 from a fresh reset (ph = 0, cnt = 0).
    do_reset();
    vecs[0] = '{3'd0, 8'h01, 1'b0, 1'b1};
    for (int k = 1; k <= 4; k++) vecs[k] = '{3'd1, 8'h01, 1'b0, 1'b1};
    vecs[4].exp_step = 1'b1;
    vecs[5] = '{3'd2, 8'h03, 1'b0, 1'b1};
    vecs[6] = '{3'd2, 8'h03, 1'b0, 1'b1};
    vecs[7] = '{3'd2, 8'h03, 1'b0, 1'b1};
    vecs[8] = '{3'd2, 8'h02, 1'b1, 1'b1};
    for (int k = 9; k <= 15; k++) vecs[k] = '{3'd2, 8'h04, 1'b0, 1'b1};
    for (int k = 16; k <= 19; k++) vecs[k] = '{3'd2, 8'h07, 1'b0, 1'b1};
    vecs[20] = '{3'd2, 8'h06, 1'b0, 1'b1};
    for (int k = 0; k < 21; k++) begin
      pos = vecs[k].pos;
      tick();
      check($sformatf("vec%0d_led", k), 32'(led), 32'(vecs[k].exp_led));
      check($sformatf("vec%0d_step", k), 32'(step), 32'(vecs[k].exp_step));
      check($sformatf("vec%0d_dir", k), 32'(dir), 32'(vecs[k].exp_dir));
    end
    duty16();
    check("asc_duty_led2", 32'(hi[2]), 32'd16);
    check("asc_duty_led1", 32'(hi[1]), 32'd8);
    check("asc_duty_led0", 32'(hi[0]), 32'd4);

    // Jump 2 -> 6 decays the trail once, then 6 -> 5 reverses direction.
    pos = 3'd6;
    wait_step(n);
    check("jump6_latency", 32'(n), 32'd4);
    check("jump6_dir", 32'(dir), 32'h1);
    pos = 3'd5;
    wait_step(n);
    check("desc5_latency", 32'(n), 32'd4);
    check("desc5_dir", 32'(dir), 32'h0);
    duty16();
    check("desc_duty_led5", 32'(hi[5]), 32'd16);
    check("desc_duty_led6", 32'(hi[6]), 32'd8);
    check("desc_duty_led2", 32'(hi[2]), 32'd4);
    check("desc_duty_led1", 32'(hi[1]), 32'd0);

    // One-cycle glitch 5 -> 7 -> 5 must be ignored.
    pos = 3'd7;
    tick();
    pos = 3'd5;
    steps = 0;
    repeat (20) begin
      tick();
      if (step === 1'b1) steps++;
    end
    check("glitch_steps", 32'(steps), 32'd0);
    duty16();
    check("glitch_duty_led5", 32'(hi[5]), 32'd16);
    check("glitch_duty_led7", 32'(hi[7]), 32'd0);

    // Blank for 50 cycles while moving 5 -> 4.
    blank = 1'b1;
    pos = 3'd4;
    bad = 0;
    steps = 0;
    repeat (50) begin
      tick();
      if (led !== 8'h00) bad++;
      if (step === 1'b1) steps++;
    end
    check("blank_led_bad", 32'(bad), 32'd0);
    check("blank_steps", 32'(steps), 32'd1);
    check("blank_dir", 32'(dir), 32'h0);
    blank = 1'b0;
    tick();
    duty16();
    check("unblank_duty_led4", 32'(hi[4]), 32'd16);
    check("unblank_duty_led5", 32'(hi[5]), 32'd8);
    check("unblank_duty_led6", 32'(hi[6]), 32'd4);
    check("unblank_duty_led2", 32'(hi[2]), 32'd0);

    // Reset while 7 is one edge from acceptance; then pos = 4 after release.
    pos = 3'd7;
    repeat (3) tick();
    clr = 1'b1;
    pos = 3'd4;
    tick();
    check("clr_step", 32'(step), 32'h0);
    check("clr_led", 32'(led), 32'h00);
    check("clr_dir", 32'(dir), 32'h1);
    clr = 1'b0;
    tick();
    check("post_clr_led", 32'(led), 32'h01);
    check("post_clr_step", 32'(step), 32'h0);
    wait_step(n);
    check("post_clr_latency", 32'(n), 32'd3);
    check("post_clr_dir", 32'(dir), 32'h1);
    duty16();
    check("post_clr_duty_led4", 32'(hi[4]), 32'd16);
    check("post_clr_duty_led0", 32'(hi[0]), 32'd8);
    check("post_clr_duty_led7", 32'(hi[7]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
